// File: rtl/vga_timing_pkg.sv
// Raster timing table and helpers shared by the VGA timing generator and its users.
package vga_timing_pkg;

    localparam int TW = 16;

    typedef struct packed {
        logic          pol;
        logic [TW-1:0] hfp;
        logic [TW-1:0] hbp;
        logic [TW-1:0] hva;
        logic [TW-1:0] htot;
        logic [TW-1:0] vfp;
        logic [TW-1:0] vbp;
        logic [TW-1:0] vva;
        logic [TW-1:0] vtot;
    } timing_t;

    localparam timing_t TIMING [4] = '{
        '{1'b0, 16'd16, 16'd112, 16'd160, 16'd800,  16'd10, 16'd12, 16'd45, 16'd525},
        '{1'b1, 16'd40, 16'd168, 16'd256, 16'd1056, 16'd1,  16'd5,  16'd28, 16'd628},
        '{1'b0, 16'd24, 16'd160, 16'd320, 16'd1344, 16'd3,  16'd9,  16'd38, 16'd806},
        '{1'b1, 16'd48, 16'd160, 16'd408, 16'd1688, 16'd1,  16'd4,  16'd42, 16'd1066}
    };

    // Packed view of the table so it can be passed as a module parameter.
    localparam timing_t [3:0] TIMING_P = {TIMING[3], TIMING[2], TIMING[1], TIMING[0]};

    function automatic logic sync_level(input logic pol, input logic in_win);
        return in_win ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Mode-request handshake and raster outputs of the VGA timing generator.
interface vga_timing_gen_if #(
    parameter int CW = 11,
    parameter int MW = 2
);
    logic [MW-1:0] mode_req;
    logic          mode_load;
    logic          mode_busy;
    logic [MW-1:0] mode_cur;
    logic          hsync;
    logic          vsync;
    logic          active;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  mode_req, mode_load,
        output mode_busy, mode_cur, hsync, vsync, active, x, y, line_start, frame_start
    );

    modport slave (
        output mode_req, mode_load,
        input  mode_busy, mode_cur, hsync, vsync, active, x, y, line_start, frame_start
    );
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth register chain with a reset value; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    generate
        if (DEPTH == 0) begin : g_wire
            logic w_unused;
            assign w_unused = clock ^ reset;
            assign o_q = i_d;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
                end else begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/vga_timing_gen.sv
// Run-time switchable raster timing generator; mode requests take effect at frame end.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int                   CW         = 11,
    parameter int                   NMODES     = 4,
    parameter int                   MW         = 2,
    parameter int                   PIPE       = 2,
    parameter int                   RESET_MODE = 0,
    parameter timing_t [NMODES-1:0] TBL        = TIMING_P[NMODES-1:0]
) (
    input  logic             clock,
    input  logic             reset,
    vga_timing_gen_if.master bus
);
    localparam timing_t         RST_T    = TBL[RESET_MODE];
    localparam logic            IDLE     = ~RST_T.pol;
    localparam logic [MW-1:0]   RST_MODE = MW'(RESET_MODE);

    function automatic timing_t lookup(input logic [MW-1:0] m);
        timing_t t;
        t = TBL[0];
        for (int i = 1; i < NMODES; i++)
            if (m == MW'(i)) t = TBL[i];
        return t;
    endfunction

    logic [CW-1:0] r_h, r_v;
    logic [MW-1:0] r_mode, r_pend;
    logic          r_busy;
    timing_t       w_t;
    logic [CW-1:0] w_hfp, w_hbp, w_hva, w_vfp, w_vbp, w_vva;
    logic          w_h_end, w_v_end, w_apply, w_load_ok;
    logic          w_hs_raw, w_vs_raw, w_act_raw;
    logic [CW-1:0] r_x_p0, r_y_p0;
    logic          r_ls_p0, r_fs_p0, r_hs_p0, r_vs_p0, r_act_p0;
    logic [2:0]    w_sync_d;

    assign w_t       = lookup(r_mode);
    assign w_hfp     = CW'(w_t.hfp);
    assign w_hbp     = CW'(w_t.hbp);
    assign w_hva     = CW'(w_t.hva);
    assign w_vfp     = CW'(w_t.vfp);
    assign w_vbp     = CW'(w_t.vbp);
    assign w_vva     = CW'(w_t.vva);
    assign w_h_end   = (r_h == CW'(w_t.htot - TW'(1)));
    assign w_v_end   = (r_v == CW'(w_t.vtot - TW'(1)));
    assign w_apply   = w_h_end && w_v_end;
    assign w_load_ok = bus.mode_load && ({1'b0, bus.mode_req} < (MW+1)'(NMODES));

    assign w_hs_raw  = sync_level(w_t.pol, (r_h >= w_hfp) && (r_h < w_hbp));
    assign w_vs_raw  = sync_level(w_t.pol, (r_v >= w_vfp) && (r_v < w_vbp));
    assign w_act_raw = (r_h >= w_hva) && (r_v >= w_vva);

    // Counters and mode control; a load in the apply cycle overrides the busy clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_h    <= '0;
            r_v    <= '0;
            r_mode <= RST_MODE;
            r_pend <= RST_MODE;
            r_busy <= 1'b0;
        end else begin
            if (w_h_end) begin
                r_h <= '0;
                r_v <= w_v_end ? '0 : r_v + CW'(1);
            end else begin
                r_h <= r_h + CW'(1);
            end
            if (w_apply) begin
                r_mode <= r_pend;
                r_busy <= 1'b0;
            end
            if (w_load_ok) begin
                r_pend <= bus.mode_req;
                r_busy <= 1'b1;
            end
        end
    end

    // Stage p0: everything registered once from the current counter value.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_x_p0   <= '0;
            r_y_p0   <= '0;
            r_ls_p0  <= 1'b0;
            r_fs_p0  <= 1'b0;
            r_hs_p0  <= IDLE;
            r_vs_p0  <= IDLE;
            r_act_p0 <= 1'b0;
        end else begin
            r_x_p0   <= w_act_raw ? (r_h - w_hva) : '0;
            r_y_p0   <= w_act_raw ? (r_v - w_vva) : '0;
            r_ls_p0  <= (r_h == '0);
            r_fs_p0  <= (r_h == '0) && (r_v == '0);
            r_hs_p0  <= w_hs_raw;
            r_vs_p0  <= w_vs_raw;
            r_act_p0 <= w_act_raw;
        end
    end

    // Stages p1..pPIPE: sync/active delayed to match renderer latency.
    vga_delay_line #(
        .WIDTH    (3),
        .DEPTH    (PIPE),
        .RESET_VAL({IDLE, IDLE, 1'b0})
    ) u_sync_dly (
        .clock (clock),
        .reset (reset),
        .i_d   ({r_hs_p0, r_vs_p0, r_act_p0}),
        .o_q   (w_sync_d)
    );

    assign bus.mode_busy   = r_busy;
    assign bus.mode_cur    = r_mode;
    assign bus.x           = r_x_p0;
    assign bus.y           = r_y_p0;
    assign bus.line_start  = r_ls_p0;
    assign bus.frame_start = r_fs_p0;
    assign bus.hsync       = w_sync_d[2];
    assign bus.vsync       = w_sync_d[1];
    assign bus.active      = w_sync_d[0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a small-table PIPE=2 instance and a real-VGA-table PIPE=0 instance.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    typedef struct packed {
        logic        busy;
        logic [2:0]  cur;
        logic        hs;
        logic        vs;
        logic        act;
        logic [10:0] x;
        logic [10:0] y;
        logic        ls;
        logic        fs;
    } exp_t;

    function automatic timing_t mk(input int pol, input int hfp, input int hbp, input int hva,
                                   input int htot, input int vfp, input int vbp, input int vva,
                                   input int vtot);
        timing_t r;
        r.pol  = 1'(pol);
        r.hfp  = 16'(hfp);
        r.hbp  = 16'(hbp);
        r.hva  = 16'(hva);
        r.htot = 16'(htot);
        r.vfp  = 16'(vfp);
        r.vbp  = 16'(vbp);
        r.vva  = 16'(vva);
        r.vtot = 16'(vtot);
        return r;
    endfunction

    localparam timing_t [3:0] T_SMALL = {
        mk(1, 0, 2, 3, 9,  2, 3, 5, 8),
        mk(0, 3, 5, 8, 12, 1, 3, 4, 7),
        mk(1, 1, 3, 5, 8,  0, 1, 2, 5),
        mk(0, 2, 4, 6, 10, 1, 2, 3, 6)
    };
    localparam int NCYC = 40000;

    logic clock = 1'b0;
    logic rst_s, rst_v;
    always #5 clock = ~clock;

    vga_timing_gen_if #(.CW(11), .MW(3)) if_s ();
    vga_timing_gen_if #(.CW(11), .MW(2)) if_v ();

    vga_timing_gen #(.CW(11), .NMODES(4), .MW(3), .PIPE(2), .RESET_MODE(1), .TBL(T_SMALL)) dut_s (
        .clock(clock), .reset(rst_s), .bus(if_s)
    );
    vga_timing_gen #(.CW(11), .NMODES(4), .MW(2), .PIPE(0), .RESET_MODE(0)) dut_v (
        .clock(clock), .reset(rst_v), .bus(if_v)
    );

    // Reference model: position within frame plus mode bookkeeping, per instance.
    timing_t    tbl [2][4];
    int         pipe_d [2];
    int         rmode_d [2];
    int         m_t [2];
    int         m_mode [2];
    int         m_pend [2];
    bit         m_busy [2];
    logic [2:0] past [2][8];
    exp_t       q_s [$];
    exp_t       q_v [$];
    int         checks = 0;
    int         fails = 0;

    function automatic int flen(input int d);
        return int'(tbl[d][m_mode[d]].htot) * int'(tbl[d][m_mode[d]].vtot);
    endfunction

    task automatic model_edge(input int d, input bit rst, input bit load, input int req,
                              output exp_t e);
        timing_t tm;
        int h, v;
        logic hs, vs, act, idle;
        e = '0;
        if (rst) begin
            m_t[d] = 0;
            m_mode[d] = rmode_d[d];
            m_pend[d] = rmode_d[d];
            m_busy[d] = 1'b0;
            idle = ~tbl[d][rmode_d[d]].pol;
            for (int k = 0; k < 8; k++) past[d][k] = {idle, idle, 1'b0};
            e.cur = 3'(rmode_d[d]);
            e.hs  = idle;
            e.vs  = idle;
            return;
        end
        tm  = tbl[d][m_mode[d]];
        h   = m_t[d] % int'(tm.htot);
        v   = m_t[d] / int'(tm.htot);
        act = (h >= int'(tm.hva)) && (v >= int'(tm.vva));
        hs  = (h >= int'(tm.hfp) && h < int'(tm.hbp)) ? tm.pol : ~tm.pol;
        vs  = (v >= int'(tm.vfp) && v < int'(tm.vbp)) ? tm.pol : ~tm.pol;
        e.x  = act ? 11'(h - int'(tm.hva)) : 11'd0;
        e.y  = act ? 11'(v - int'(tm.vva)) : 11'd0;
        e.ls = (h == 0);
        e.fs = (m_t[d] == 0);
        for (int k = 7; k > 0; k--) past[d][k] = past[d][k-1];
        past[d][0] = {hs, vs, act};
        {e.hs, e.vs, e.act} = past[d][pipe_d[d]];
        if (m_t[d] == flen(d) - 1) begin
            m_t[d] = 0;
            if (m_busy[d]) m_mode[d] = m_pend[d];
            m_busy[d] = 1'b0;
        end else begin
            m_t[d]++;
        end
        if (load && req < 4) begin
            m_pend[d] = req;
            m_busy[d] = 1'b1;
        end
        e.busy = m_busy[d];
        e.cur  = 3'(m_mode[d]);
    endtask

    // Stimulus: drives on the falling edge and pushes the expected post-edge outputs.
    initial begin
        exp_t e;
        int   req_s, req_v;
        bit   ld_s, ld_v, rs, rv, did_apply;
        rst_s = 1'b1;
        rst_v = 1'b1;
        if_s.mode_load = 1'b0;
        if_s.mode_req  = '0;
        if_v.mode_load = 1'b0;
        if_v.mode_req  = '0;
        pipe_d  = '{2, 0};
        rmode_d = '{1, 0};
        for (int i = 0; i < 4; i++) begin
            tbl[0][i] = T_SMALL[i];
            tbl[1][i] = TIMING[i];
        end
        did_apply = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clock);
            rs    = (c < 3) || (c == 1000) || ($urandom_range(0, 2999) == 0);
            rv    = (c < 3);
            ld_s  = ($urandom_range(0, 24) == 0) || (c == 995);
            req_s = (c == 995) ? 2 : int'($urandom_range(0, 7));
            if (!did_apply && c > 2000 && !rs && m_t[0] == flen(0) - 1) begin
                ld_s = 1'b1;
                req_s = 3;
                did_apply = 1'b1;
            end
            ld_v  = (c == 5000);
            req_v = 2;
            rst_s = rs;
            rst_v = rv;
            if_s.mode_load = ld_s;
            if_s.mode_req  = 3'(req_s);
            if_v.mode_load = ld_v;
            if_v.mode_req  = 2'(req_v);
            model_edge(0, rs, ld_s, req_s, e);
            q_s.push_back(e);
            model_edge(1, rv, ld_v, req_v, e);
            q_v.push_back(e);
        end
        @(negedge clock);
        if_s.mode_load = 1'b0;
        if_v.mode_load = 1'b0;
        @(posedge clock);
        #2;
        checks++;
        if (q_s.size() + q_v.size() != 0) begin
            fails++;
            $display("FAIL drain pending=%0d required=0", q_s.size() + q_v.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    // Monitor: pops one expectation per instance after every rising edge.
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clock);
            #1;
            if (q_s.size() > 0) begin
                e = q_s.pop_front();
                a = {if_s.mode_busy, if_s.mode_cur, if_s.hsync, if_s.vsync, if_s.active,
                     if_s.x, if_s.y, if_s.line_start, if_s.frame_start};
                checks++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL sb_small t=%0t got=%h required=%h", $time, a, e);
                end
            end
            if (q_v.size() > 0) begin
                e = q_v.pop_front();
                a = {if_v.mode_busy, 1'b0, if_v.mode_cur, if_v.hsync, if_v.vsync, if_v.active,
                     if_v.x, if_v.y, if_v.line_start, if_v.frame_start};
                checks++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL sb_vga t=%0t got=%h required=%h", $time, a, e);
                end
            end
        end
    end
endmodule
